// File: rtl/vec_func_pkg.sv
// Shared types and the pure evaluation function for the vector-function pipeline.
// The pipeline carries only the evaluated result record, never the raw sample.
package vec_func_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        MODE_ALL = 1'b0,
        MODE_PAR = 1'b1
    } mode_e;

    typedef struct packed {
        logic x;
        logic y;
        logic z;
        logic par;
    } vec_res_t;

    localparam vec_res_t RES_ZERO = 4'b0000;

    // Evaluates one sample of width w (bits above w are ignored).
    // Bit 0 is a, bit 1 is b, bits 2..w-2 are the c group, bit w-1 is e.
    function automatic vec_res_t vec_eval(
        input logic [MAX_W-1:0] data,
        input int               w,
        input mode_e            mode
    );
        vec_res_t res;
        logic     all_and;
        logic     mid_or;
        logic     par;
        logic     e_bit;
        all_and = 1'b1;
        mid_or  = 1'b0;
        par     = 1'b0;
        e_bit   = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                all_and = all_and & data[i];
                if (i >= 1) begin
                    par = par ^ data[i];
                end else begin
                    par = par;
                end
                if ((i >= 2) && (i <= w - 2)) begin
                    mid_or = mid_or | data[i];
                end else begin
                    mid_or = mid_or;
                end
                if (i == w - 1) begin
                    e_bit = data[i];
                end else begin
                    e_bit = e_bit;
                end
            end else begin
                all_and = all_and;
            end
        end
        res.x   = data[0] & data[1] & ~e_bit & mid_or;
        res.y   = ~all_and;
        res.par = par;
        res.z   = (mode == MODE_PAR) ? par : (res.x | res.y | par);
        return res;
    endfunction

endpackage

// File: rtl/vec_func_stage.sv
// One pipeline register holding a result record and its valid flag.
// It loads whenever it is empty or its downstream consumer takes the current entry.
module vec_func_stage
    import vec_func_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  vec_res_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output vec_res_t out_data
);

    logic     valid_r;
    vec_res_t data_r;
    logic     load_s;

    assign load_s = ~valid_r | out_ready;

    // Register the record; an empty slot always holds zeros so outputs read 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= RES_ZERO;
        end else if (load_s) begin
            valid_r <= in_valid;
            data_r  <= in_valid ? in_data : RES_ZERO;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/vec_func_pipe.sv
// Evaluates x/y/z/par at entry, carries the record through STAGES valid/ready
// registers and counts delivered z=1 results in a saturating counter.
module vec_func_pipe
    import vec_func_pkg::*;
#(
    parameter int W      = 5,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_x,
    output logic             out_y,
    output logic             out_z,
    output logic             out_par,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [MAX_W-1:0] data_ext_s;
    logic [STAGES:0]  vld_s;
    logic [STAGES:0]  take_s;
    vec_res_t         dat_s [STAGES+1];
    logic             deliver_z_s;
    logic [CNT_W-1:0] cnt_r;

    assign data_ext_s = MAX_W'(in_data);
    assign vld_s[0]   = in_valid;
    assign dat_s[0]   = vec_eval(data_ext_s, W, mode_e'(mode));

    // take_s[g] is high when stage g can load: it is empty or the stage after it moves.
    always_comb begin
        take_s         = {(STAGES+1){1'b0}};
        take_s[STAGES] = out_ready;
        for (int g = STAGES - 1; g >= 0; g--) begin
            take_s[g] = ~vld_s[g+1] | take_s[g+1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        vec_func_stage u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld_s[g]),
            .in_data   (dat_s[g]),
            .out_valid (vld_s[g+1]),
            .out_ready (take_s[g+1]),
            .out_data  (dat_s[g+1])
        );
    end

    assign in_ready    = take_s[0];
    assign out_valid   = vld_s[STAGES];
    assign out_x       = dat_s[STAGES].x;
    assign out_y       = dat_s[STAGES].y;
    assign out_z       = dat_s[STAGES].z;
    assign out_par     = dat_s[STAGES].par;
    assign deliver_z_s = vld_s[STAGES] & out_ready & dat_s[STAGES].z;

    // Saturating count of delivered z=1 results; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (deliver_z_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign evt_cnt = cnt_r;

endmodule

// File: tb/tb_vec_func_pipe.sv
// Directed and randomized bench for vec_func_pipe: three instances (W/STAGES/CNT_W of
// 5/2/2, 3/1/8 and 8/4/4) scored against an arithmetic reference model and FIFO.
module tb_vec_func_pipe;

    localparam int NI = 3;
    localparam int WID  [NI] = '{5, 3, 8};
    localparam int CMAX [NI] = '{3, 255, 15};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv, orr, md, clr;
    logic [2:0]  ir, ov, ox, oy, oz, op;
    logic [31:0] idat [NI];
    logic [1:0]  ec_a;
    logic [7:0]  ec_b;
    logic [3:0]  ec_c;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  q [NI][$];
    int          cnt [NI];
    bit          hold [NI];
    logic [3:0]  held [NI];

    always #5 clk = ~clk;

    vec_func_pipe #(.W(5), .STAGES(2), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][4:0]),
        .mode(md[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_x(ox[0]), .out_y(oy[0]),
        .out_z(oz[0]), .out_par(op[0]), .clr_cnt(clr[0]), .evt_cnt(ec_a)
    );

    vec_func_pipe #(.W(3), .STAGES(1), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1][2:0]),
        .mode(md[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_x(ox[1]), .out_y(oy[1]),
        .out_z(oz[1]), .out_par(op[1]), .clr_cnt(clr[1]), .evt_cnt(ec_b)
    );

    vec_func_pipe #(.W(8), .STAGES(4), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2][7:0]),
        .mode(md[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_x(ox[2]), .out_y(oy[2]),
        .out_z(oz[2]), .out_par(op[2]), .clr_cnt(clr[2]), .evt_cnt(ec_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] evt(input int i);
        case (i)
            0:       return 32'(ec_a);
            1:       return 32'(ec_b);
            default: return 32'(ec_c);
        endcase
    endfunction

    // Reference result {x, y, z, par} from masks and population count.
    function automatic logic [3:0] ref_eval(input logic [31:0] d, input int w, input logic m);
        logic [31:0] mask, v, mid;
        logic        x, y, p, z;
        mask = (32'd1 << w) - 32'd1;
        v    = d & mask;
        mid  = (v >> 2) & ((32'd1 << (w - 3)) - 32'd1);
        x    = v[0] && v[1] && !v[w-1] && (mid != 32'd0);
        y    = (v != mask);
        p    = ($countones(v >> 1) % 2) == 1;
        z    = m ? p : (x | y | p);
        return {x, y, z, p};
    endfunction

    function automatic logic [3:0] dut_out(input int i);
        return {ox[i], oy[i], oz[i], op[i]};
    endfunction

    // Score one cycle for every instance (inputs already driven), then advance a clock.
    task automatic tick();
        logic [3:0] obs, exp;
        #1;
        for (int i = 0; i < NI; i++) begin
            obs = dut_out(i);
            if (hold[i]) begin
                chk($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
                chk($sformatf("hold_data%0d", i), 32'(obs), 32'(held[i]));
            end
            chk($sformatf("evt_cnt%0d", i), evt(i), 32'(cnt[i]));
            if (!ov[i]) chk($sformatf("idle_zero%0d", i), 32'(obs), 32'd0);
            if (ov[i] && orr[i]) begin
                chk($sformatf("not_stale%0d", i), 32'(q[i].size() != 0), 32'd1);
                if (q[i].size() != 0) begin
                    exp = q[i].pop_front();
                    chk($sformatf("deliver%0d", i), 32'(obs), 32'(exp));
                    if (!clr[i] && exp[1] && cnt[i] < CMAX[i]) cnt[i]++;
                end
            end
            if (clr[i]) cnt[i] = 0;
            hold[i] = ov[i] && !orr[i];
            held[i] = obs;
            if (iv[i] && ir[i]) q[i].push_back(ref_eval(idat[i], WID[i], md[i]));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [31:0] d, input logic m);
        iv[0]   = v;
        idat[0] = d;
        md[0]   = m;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iv = 3'b000; orr = 3'b111; md = 3'b000; clr = 3'b000;
        for (int i = 0; i < NI; i++) begin
            idat[i] = 32'd0; cnt[i] = 0; hold[i] = 1'b0; held[i] = 4'd0;
        end
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_outs", 32'({ox, oy, oz, op}), 32'd0);
        chk("rst_evt_a", evt(0), 32'd0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ready_after_rst", 32'(ir), 32'b111);

        // Directed values, two-cycle latency
        set0(1'b1, 32'b00111, 1'b0); tick();
        chk("latency_not_early", 32'(ov[0]), 32'd0);
        set0(1'b1, 32'b11111, 1'b0); tick();
        chk("t1a_valid", 32'(ov[0]), 32'd1);
        chk("t1a_xyzp", 32'(dut_out(0)), 32'b1110);
        set0(1'b0, 32'd0, 1'b0); tick();
        chk("t1b_valid", 32'(ov[0]), 32'd1);
        chk("t1b_xyzp", 32'(dut_out(0)), 32'b0000);
        tick();
        chk("t1_drained", 32'(ov[0]), 32'd0);

        set0(1'b1, 32'b00011, 1'b1); tick();
        set0(1'b1, 32'b11110, 1'b1); tick();
        chk("t2a_xyzp", 32'(dut_out(0)), 32'b0111);
        set0(1'b0, 32'd0, 1'b0); tick();
        chk("t2b_xyzp", 32'(dut_out(0)), 32'b0100);
        tick();

        // Backpressure: out_ready low for three cycles with continuous input
        orr[0] = 1'b0;
        set0(1'b1, 32'd9, 1'b0);  #1 chk("bp_ready_c1", 32'(ir[0]), 32'd1); tick();
        set0(1'b1, 32'd18, 1'b1); #1 chk("bp_ready_c2", 32'(ir[0]), 32'd1); tick();
        set0(1'b1, 32'd27, 1'b0); #1 chk("bp_ready_c3", 32'(ir[0]), 32'd0);
        chk("bp_valid_c3", 32'(ov[0]), 32'd1); tick();
        orr[0] = 1'b1;
        #1 chk("bp_ready_c4", 32'(ir[0]), 32'd1); tick();
        set0(1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("bp_all_delivered", 32'(q[0].size()), 32'd0);

        // Saturation and clear priority
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set0(1'b1, 32'b00111, 1'b0); tick();
        end
        set0(1'b0, 32'd0, 1'b0); tick(); tick();
        chk("evt_saturated", evt(0), 32'd3);
        set0(1'b1, 32'b00111, 1'b0); tick();
        set0(1'b0, 32'd0, 1'b0); tick();
        chk("clr_z_pending", 32'({ov[0], oz[0]}), 32'b11);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("clr_wins", evt(0), 32'd0);

        // Reset mid-stream with two samples in flight
        set0(1'b1, 32'b00111, 1'b0); tick();
        set0(1'b0, 32'd0, 1'b0); tick(); tick();
        orr[0] = 1'b0;
        set0(1'b1, 32'b00111, 1'b0); tick();
        set0(1'b1, 32'b00011, 1'b0); tick();
        chk("inflight_valid", 32'(ov[0]), 32'd1);
        chk("inflight_evt", evt(0), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ov), 32'd0);
        chk("midrst_outs", 32'({ox, oy, oz, op}), 32'd0);
        chk("midrst_evt", evt(0), 32'd0);
        for (int i = 0; i < NI; i++) begin
            q[i].delete(); cnt[i] = 0; hold[i] = 1'b0;
        end
        set0(1'b0, 32'd0, 1'b0); orr = 3'b111;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("no_stale", 32'(ov[0]), 32'd0);
        end

        // Randomized streams on all three configurations
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NI; i++) begin
                iv[i]   = $urandom_range(0, 3) != 0;
                idat[i] = $urandom;
                md[i]   = $urandom_range(0, 1) == 1;
                orr[i]  = (k < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
                clr[i]  = $urandom_range(0, 40) == 0;
            end
            tick();
        end
        iv = 3'b000; orr = 3'b111; clr = 3'b000;
        for (int k = 0; k < 8; k++) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rand_drained%0d", i), 32'(q[i].size()), 32'd0);
            chk($sformatf("rand_evt%0d", i), evt(i), 32'(cnt[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_func_pipe.md
VEC_FUNC_PIPE -- requirements
Module: vec_func_pipe

Interface
REQ-001 SHALL have parameter W, default 5, meaning input vector width (legal 3..32).
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline depth in registers (legal 1..4).
REQ-003 SHALL have parameter CNT_W, default 8, meaning event counter width (legal 2..32).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input sample present.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port in_data  input  W  sample; bit0=a, bit1=b, bit2..W-2=c.., bitW-1=e.
REQ-009 SHALL have port mode  input  1  z select, sampled with each accepted sample.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports out_x, out_y, out_z, out_par  output  1 each  registered results.
REQ-013 SHALL have port clr_cnt  input  1  synchronous counter clear.
REQ-014 SHALL have port evt_cnt  output  CNT_W  saturating count of delivered z=1 results.

Function
REQ-015 SHALL compute x = a & b & ~e & (OR of bits 2..W-2).
REQ-016 SHALL compute y = NOT(AND of all W bits).
REQ-017 SHALL compute par = XOR of bits 1..W-1.
REQ-018 SHALL compute z = x|y|par when mode=0, z = par when mode=1.
REQ-019 SHALL accept a sample when in_valid & in_ready, and deliver a result when out_valid & out_ready.
REQ-020 SHALL evaluate x/y/par/z combinationally at entry and carry the results, not in_data, through the pipeline.
REQ-021 SHALL advance each stage when it is empty or the next stage advances (per-stage valid bit, no bubbles held).
REQ-022 SHALL assert in_ready = (stage 1 empty) OR (stage 1 advances this cycle).
REQ-023 SHALL have latency exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
REQ-024 SHALL sustain one sample per cycle with out_ready high.
REQ-025 SHALL hold out_valid and all out_* stable while out_valid & ~out_ready.
REQ-026 SHALL drop and lose no sample under any out_ready pattern; order preserved.
REQ-027 SHALL accept a new sample in the same cycle the full pipeline delivers one.
REQ-028 SHALL increment evt_cnt on each delivery with out_z=1, saturating at 2^CNT_W-1.
REQ-029 SHALL clear evt_cnt to 0 on clr_cnt; clr_cnt wins over a simultaneous increment.
REQ-030 SHALL drive out_x/y/z/par to 0 whenever out_valid=0.

Reset
REQ-031 SHALL on rst, asynchronously, clear all stage valids, out_*=0, out_valid=0, evt_cnt=0.
REQ-032 SHALL drive in_ready=1 from the first clock edge after rst deasserts.
REQ-033 SHALL discard in-flight samples on reset mid-operation; none reappear afterwards.

Structure
REQ-034 SHALL place the result record type (x,y,z,par), the mode enum and the pure evaluation function in shared package vec_func_pkg.
REQ-035 SHALL implement one pipeline register with valid/ready as sub-module vec_func_stage, instantiated STAGES times by generate.
REQ-036 SHALL contain the saturating counter in the top module.

Verification (W=5, STAGES=2, CNT_W=2 unless stated)
REQ-037 SHALL test in_data=5'b00111, mode=0 -> two cycles later x=1, y=1, par=0, z=1; in_data=5'b11111 -> x=0, y=0, par=0, z=0.
REQ-038 SHALL test 5'b00011 mode=1 -> x=0, y=1, par=1, z=1; and 5'b11110 mode=1 -> x=0, y=1, par=0, z=0.
REQ-039 SHALL test continuous input with out_ready low for 3 cycles -> in_ready falls after 2 accepted samples, outputs stable, all samples delivered in order.
REQ-040 SHALL test 5 deliveries with z=1 -> evt_cnt saturates at 3; clr_cnt with a z=1 delivery same cycle -> evt_cnt=0.
REQ-041 SHALL test rst asserted mid-stream with 2 samples in flight -> out_valid=0, evt_cnt=0 immediately, no stale result after release.
REQ-042 SHALL test random streams with random out_ready for W in {3,5,8}, STAGES in {1,4} against a package-function reference model.
